direction_accumulator: RTL and testbench

- Sits directly downstream of the per-bin direction calculator in the localization path.
- Consumes one packed direction vector per FFT bin: y in [31:16], x in [15:0], each signed 7.9 fixed point.
- Sums x and y over a configurable bin window for each frame and emits one frame-level direction vector over a valid/ready handshake.
- The output feeds the angle/heading stage.

---
 rtl/localization_pkg.sv | 13 +
 rtl/direction_accumulator_dir_narrow.sv | 36 +++
 rtl/direction_accumulator.sv | 123 ++++++++++++
 tb/tb_direction_accumulator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/localization_pkg.sv
// Shared types and constants for the localization path.
//   direction_t   : packed {y, x} direction vector, each axis signed 7.9 fixed point
//   VEC_FRAC_BITS : number of fractional bits on each axis
package localization_pkg;

  localparam int VEC_FRAC_BITS = 9;

  typedef struct packed {
    logic signed [15:0] y;
    logic signed [15:0] x;
  } direction_t;

endpackage

// File: rtl/direction_accumulator_dir_narrow.sv
// dir_narrow: reduces one accumulated axis sum to a 16-bit signed value.
// The sum is arithmetically shifted right by OUT_SHIFT, then reduced to 16 bits.
// Build option DIR_ACC_SATURATE_EN: when defined, the shifted value clamps to
// [-32768, 32767]; when undefined, the low 16 bits are kept (two's-complement wrap).
// Ports:
//   sum_in  : ACC_W-bit signed axis sum
//   val_out : 16-bit narrowed axis value
module dir_narrow #(
  parameter int ACC_W     = 28,
  parameter int OUT_SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] sum_in,
  output logic        [15:0]      val_out
);

  logic signed [ACC_W-1:0] shifted;

  assign shifted = sum_in >>> OUT_SHIFT;

`ifdef DIR_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);

  always_comb begin
    val_out = 16'(shifted);
    if (shifted > MAX_V) begin
      val_out = 16'h7FFF;
    end else if (shifted < MIN_V) begin
      val_out = 16'h8000;
    end
  end
`else
  assign val_out = 16'(shifted);
`endif

endmodule

// File: rtl/direction_accumulator.sv
// direction_accumulator: sums per-bin direction vectors over the bin window
// [LOW_BIN, HIGH_BIN] of each frame and emits one frame-level direction vector.
// Build option DIR_ACC_SATURATE_EN selects saturating narrowing (see dir_narrow).
// Ports:
//   clk_in        : system clock
//   rst_in        : asynchronous active-high reset
//   vector_in     : {y, x} per-bin vector, signed 7.9 each
//   valid_in      : vector_in valid (no backpressure upstream)
//   last_in       : final bin of the frame, qualified by valid_in
//   direction_out : {y, x} frame result
//   count_out     : number of bins summed into direction_out
//   valid_out     : result available
//   ready_in      : downstream accepts the result
//   overrun_out   : one-cycle pulse when an unconsumed result is overwritten
//
// Output handshake: a result transfers on every cycle where valid_out && ready_in.
// valid_out and direction_out/count_out hold until that transfer. A new result
// loading while a held result is not being transferred replaces it and pulses
// overrun_out; a new result loading on a transfer cycle is a clean hand-off.
module direction_accumulator
  import localization_pkg::*;
#(
  parameter int BIN_W     = 10,
  parameter int LOW_BIN   = 4,
  parameter int HIGH_BIN  = 64,
  parameter int ACC_W     = 28,
  parameter int OUT_SHIFT = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [31:0]      vector_in,
  input  logic             valid_in,
  input  logic             last_in,
  output logic [31:0]      direction_out,
  output logic [BIN_W:0]   count_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             overrun_out
);

  if (ACC_W < 16 + BIN_W) begin : g_acc_w_check
    $error("direction_accumulator: ACC_W must be >= 16+BIN_W");
  end
  if (LOW_BIN > HIGH_BIN || HIGH_BIN >= (1 << BIN_W)) begin : g_window_check
    $error("direction_accumulator: need LOW_BIN <= HIGH_BIN < 2**BIN_W");
  end

  localparam logic [BIN_W-1:0] LOW_B   = BIN_W'(LOW_BIN);
  localparam logic [BIN_W-1:0] HIGH_B  = BIN_W'(HIGH_BIN);
  localparam logic [BIN_W-1:0] BIN_MAX = '1;

  direction_t              vin;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic signed [ACC_W-1:0] ext_x, ext_y;
  logic signed [ACC_W-1:0] sum_x, sum_y;
  logic [BIN_W-1:0]        bin_cnt;
  logic [BIN_W:0]          sum_cnt, sum_cnt_nxt;
  logic                    in_win;
  logic [15:0]             nar_x, nar_y;
  logic [31:0]             dir_q;

  assign vin    = vector_in;
  assign in_win = (bin_cnt >= LOW_B) && (bin_cnt <= HIGH_B);
  assign ext_x  = {{(ACC_W-16){vin.x[15]}}, vin.x};
  assign ext_y  = {{(ACC_W-16){vin.y[15]}}, vin.y};

  // Running sums including the current beat; the closing beat's contribution
  // goes straight into the narrowed result without passing through acc_*.
  assign sum_x       = acc_x + (in_win ? ext_x : '0);
  assign sum_y       = acc_y + (in_win ? ext_y : '0);
  assign sum_cnt_nxt = sum_cnt + {{BIN_W{1'b0}}, in_win};

  dir_narrow #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) u_narrow_x (
    .sum_in  (sum_x),
    .val_out (nar_x)
  );

  dir_narrow #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) u_narrow_y (
    .sum_in  (sum_y),
    .val_out (nar_y)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_x       <= '0;
      acc_y       <= '0;
      bin_cnt     <= '0;
      sum_cnt     <= '0;
      dir_q       <= '0;
      count_out   <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
      if (valid_in) begin
        if (last_in) begin
          // Frame close: publish the result and start the next frame at bin 0.
          acc_x       <= '0;
          acc_y       <= '0;
          bin_cnt     <= '0;
          sum_cnt     <= '0;
          dir_q       <= {nar_y, nar_x};
          count_out   <= sum_cnt_nxt;
          valid_out   <= 1'b1;
          overrun_out <= valid_out && !ready_in;
        end else begin
          acc_x   <= sum_x;
          acc_y   <= sum_y;
          sum_cnt <= sum_cnt_nxt;
          if (bin_cnt != BIN_MAX) begin
            bin_cnt <= bin_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign direction_out = dir_q;

endmodule

// File: tb/tb_direction_accumulator.sv
// Bench for direction_accumulator. Two instances share clock, reset, vector,
// last and ready; each has its own valid_in:
//   dut_a : LOW_BIN=2, HIGH_BIN=5, OUT_SHIFT=2
//   dut_b : LOW_BIN=4, HIGH_BIN=7, OUT_SHIFT=0 (saturation / empty window)
module tb_direction_accumulator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] vector_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_a, valid_b;

  logic [31:0] dir_a, dir_b;
  logic [10:0] cnt_a, cnt_b;
  logic        vout_a, vout_b;
  logic        ovr_a, ovr_b;

  int          total = 0;
  int          bad   = 0;
  int          ov_seen_a = 0;
  int          ov_seen_b = 0;
  logic [15:0] cyc = '0;

  // Entry: {expected cycle (16'hFFFF = don't check), count, direction}
  logic [58:0] exp_q_a[$];
  logic [58:0] exp_q_b[$];

  direction_accumulator #(
    .BIN_W(10), .LOW_BIN(2), .HIGH_BIN(5), .ACC_W(28), .OUT_SHIFT(2)
  ) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .vector_in(vector_in), .valid_in(valid_a),
    .last_in(last_in), .direction_out(dir_a), .count_out(cnt_a),
    .valid_out(vout_a), .ready_in(ready_in), .overrun_out(ovr_a)
  );

  direction_accumulator #(
    .BIN_W(10), .LOW_BIN(4), .HIGH_BIN(7), .ACC_W(28), .OUT_SHIFT(0)
  ) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .vector_in(vector_in), .valid_in(valid_b),
    .last_in(last_in), .direction_out(dir_b), .count_out(cnt_b),
    .valid_out(vout_b), .ready_in(ready_in), .overrun_out(ovr_b)
  );

  // Clock / cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 16'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: n consecutive beats of the same vector, optionally closing the frame.
  task automatic send_beats(input bit to_b, input int n, input logic [15:0] x,
                            input logic [15:0] y, input bit close);
    for (int i = 0; i < n; i++) begin
      vector_in = {y, x};
      last_in   = close && (i == n - 1);
      if (to_b) valid_b = 1'b1;
      else      valid_a = 1'b1;
      @(posedge clk_in);
      #1;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    last_in = 1'b0;
  endtask

  // Called right after the closing beat has been clocked in: the result must
  // be visible during the current cycle.
  task automatic push_exp(input bit to_b, input logic [31:0] dir,
                          input logic [10:0] cnt, input bit lat);
    logic [58:0] e;
    e = {(lat ? cyc : 16'hFFFF), cnt, dir};
    if (to_b) exp_q_b.push_back(e);
    else      exp_q_a.push_back(e);
  endtask

  // Scoreboard monitors
  always @(negedge clk_in) begin
    logic [58:0] e;
    if (!rst_in) begin
      if (ovr_a) ov_seen_a++;
      if (vout_a && ready_in) begin
        if (exp_q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected: got result %0h expected none", dir_a);
        end else begin
          e = exp_q_a.pop_front();
          check("a_dir", 64'(dir_a), 64'(e[31:0]));
          check("a_cnt", 64'(cnt_a), 64'(e[42:32]));
          if (e[58:43] != 16'hFFFF) check("a_latency", 64'(cyc), 64'(e[58:43]));
        end
      end
    end
  end

  always @(negedge clk_in) begin
    logic [58:0] e;
    if (!rst_in) begin
      if (ovr_b) ov_seen_b++;
      if (vout_b && ready_in) begin
        if (exp_q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected: got result %0h expected none", dir_b);
        end else begin
          e = exp_q_b.pop_front();
          check("b_dir", 64'(dir_b), 64'(e[31:0]));
          check("b_cnt", 64'(cnt_b), 64'(e[42:32]));
          if (e[58:43] != 16'hFFFF) check("b_latency", 64'(cyc), 64'(e[58:43]));
        end
      end
    end
  end

  initial begin
    rst_in    = 1'b1;
    vector_in = '0;
    last_in   = 1'b0;
    ready_in  = 1'b1;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_valid_a", 64'(vout_a), 64'd0);
    check("rst_dir_a",   64'(dir_a),  64'd0);
    check("rst_cnt_a",   64'(cnt_a),  64'd0);
    check("rst_ovr_a",   64'(ovr_a),  64'd0);
    check("rst_valid_b", 64'(vout_b), 64'd0);
    check("rst_dir_b",   64'(dir_b),  64'd0);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Window sum: bins 2..5 of 8 beats, x=16 y=-16, shifted by 2.
    send_beats(1'b0, 8, 16'h0010, 16'hFFF0, 1'b1);
    push_exp(1'b0, 32'hFFF0_0010, 11'd4, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    // Back-to-back frames: A (6 beats) then B (3 beats) with no gap.
    send_beats(1'b0, 6, 16'h0014, 16'h0100, 1'b1);
    push_exp(1'b0, 32'h0100_0014, 11'd4, 1'b1);
    send_beats(1'b0, 3, 16'h0400, 16'hFFC0, 1'b1);
    push_exp(1'b0, 32'hFFF0_0100, 11'd1, 1'b1);

    // Single-beat frame: bin 0 is outside the window.
    send_beats(1'b0, 1, 16'h7FFF, 16'h7FFF, 1'b1);
    push_exp(1'b0, 32'h0000_0000, 11'd0, 1'b1);

    // New result loading on the same edge as a handshake: no overrun.
    send_beats(1'b0, 3, 16'h0008, 16'h0004, 1'b1);
    push_exp(1'b0, 32'h0001_0002, 11'd1, 1'b1);
    send_beats(1'b0, 1, 16'h0020, 16'h0020, 1'b1);
    push_exp(1'b0, 32'h0000_0000, 11'd0, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    // Backpressure: two frame closes while ready_in=0; first result is overwritten.
    ready_in = 1'b0;
    send_beats(1'b0, 3, 16'h0020, 16'h0020, 1'b1);
    send_beats(1'b0, 4, 16'h0040, 16'hFF80, 1'b1);
    push_exp(1'b0, 32'hFFC0_0020, 11'd2, 1'b0);
    repeat (3) @(posedge clk_in);
    #1;
    check("hold_valid_a", 64'(vout_a), 64'd1);
    check("hold_dir_a",   64'(dir_a),  64'hFFC0_0020);
    check("hold_cnt_a",   64'(cnt_a),  64'd2);
    ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("cleared_valid_a", 64'(vout_a), 64'd0);

    // dut_b: saturation on both axes, bins 4..7, no shift.
    send_beats(1'b1, 8, 16'h7000, 16'h9000, 1'b1);
`ifdef DIR_ACC_SATURATE_EN
    push_exp(1'b1, 32'h8000_7FFF, 11'd4, 1'b1);
`else
    push_exp(1'b1, 32'h4000_C000, 11'd4, 1'b1);
`endif
    repeat (2) @(posedge clk_in);
    #1;

    // dut_b: empty window (3 beats, window starts at bin 4).
    send_beats(1'b1, 3, 16'h1234, 16'h4321, 1'b1);
    push_exp(1'b1, 32'h0000_0000, 11'd0, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    // dut_b: frame ending exactly on the first window bin.
    send_beats(1'b1, 5, 16'h0123, 16'hFFFE, 1'b1);
    push_exp(1'b1, 32'hFFFE_0123, 11'd1, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;

    // Reset mid-frame with a held result pending on dut_a.
    ready_in = 1'b0;
    send_beats(1'b0, 3, 16'h0010, 16'h0010, 1'b1);
    send_beats(1'b0, 5, 16'h0200, 16'h0200, 1'b0);
    #3;
    rst_in = 1'b1;
    #1;
    check("midrst_valid_a", 64'(vout_a), 64'd0);
    check("midrst_dir_a",   64'(dir_a),  64'd0);
    check("midrst_cnt_a",   64'(cnt_a),  64'd0);
    check("midrst_ovr_a",   64'(ovr_a),  64'd0);
    @(posedge clk_in);
    #1;
    rst_in   = 1'b0;
    ready_in = 1'b1;
    send_beats(1'b0, 8, 16'h0100, 16'h0080, 1'b1);
    push_exp(1'b0, 32'h0080_0100, 11'd4, 1'b1);

    // Drain with a bounded wait.
    for (int i = 0; i < 100 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++) begin
      @(posedge clk_in);
    end
    #1;
    check("drain_a", 64'(exp_q_a.size()), 64'd0);
    check("drain_b", 64'(exp_q_b.size()), 64'd0);
    check("overrun_pulses_a", 64'(ov_seen_a), 64'd1);
    check("overrun_pulses_b", 64'(ov_seen_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
